// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand forwarding and load-use hazard control for the 5-stage pipeline.
//
// Forwarding (combinational, per source slot i):
//   fwd_sel  : 2'b10 take EX/MEM result, 2'b01 take MEM/WB value,
//              2'b00 take the register-file value latched in ID/EX.
//   fwd_data : the selected operand. Register 0 is never forwarded.
//
// Hazard control:
//   A load in ID/EX whose destination is read by the instruction in ID
//   holds PC and IF/ID (stall) and injects a bubble into ID/EX for
//   LOAD_LAT consecutive cycles. A flush aborts any stall.
//   stall_cnt counts stall cycles since reset and saturates at all-ones.
//
// Ports:
//   clk, reset (async, active-high), flush (sync)
//   ex_rs_addr/ex_rs_data            EX-stage source numbers and RF values
//   ex_mem_regwrite/_rd/_data        EX/MEM write-back candidate
//   mem_wb_regwrite/_rd/_data        MEM/WB write-back candidate
//   id_rs_addr/id_rs_used            ID-stage sources and "actually read" flags
//   id_ex_memread/id_ex_rd           load in ID/EX and its destination
//   fwd_sel, fwd_data                per-slot forwarding outputs
//   stall, bubble, stall_cnt         pipeline control and perf counter
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_SRC*RADDR_W-1:0]  ex_rs_addr,
    input  logic [NUM_SRC*DATA_W-1:0]   ex_rs_data,
    input  logic                        ex_mem_regwrite,
    input  logic [RADDR_W-1:0]          ex_mem_rd,
    input  logic [DATA_W-1:0]           ex_mem_data,
    input  logic                        mem_wb_regwrite,
    input  logic [RADDR_W-1:0]          mem_wb_rd,
    input  logic [DATA_W-1:0]           mem_wb_data,
    input  logic [NUM_SRC*RADDR_W-1:0]  id_rs_addr,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic                        id_ex_memread,
    input  logic [RADDR_W-1:0]          id_ex_rd,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic                        stall,
    output logic                        bubble,
    output logic [CNT_W-1:0]            stall_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // Remaining stall cycles after the first one, loaded when STALL is entered.
    localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

    // -------------------------------------------------------------------------
    // Forwarding: one independent mux per source slot.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        logic [RADDR_W-1:0] rs;
        logic [DATA_W-1:0]  rf_val;
        logic [1:0]         sel;

        assign rs     = ex_rs_addr[i*RADDR_W +: RADDR_W];
        assign rf_val = ex_rs_data[i*DATA_W +: DATA_W];

        // EX/MEM is checked first: it holds the younger result when both
        // stages write the same register.
        always_comb begin
            // NOTE: every combinational output gets a default before any
            // conditional assignment so no path leaves it unassigned (no latch).
            sel = 2'b00;
            if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs))
                sel = 2'b10;
            else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs))
                sel = 2'b01;
        end

        assign fwd_sel[2*i +: 2] = sel;

        always_comb begin
            case (sel)
                2'b10:   fwd_data[i*DATA_W +: DATA_W] = ex_mem_data;
                2'b01:   fwd_data[i*DATA_W +: DATA_W] = mem_wb_data;
                2'b00:   fwd_data[i*DATA_W +: DATA_W] = rf_val;
                default: fwd_data[i*DATA_W +: DATA_W] = '0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load-use hazard detection against the instruction in ID.
    // -------------------------------------------------------------------------
    logic rs_match;
    logic haz;

    always_comb begin
        rs_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs_addr[i*RADDR_W +: RADDR_W] == id_ex_rd))
                rs_match = 1'b1;
        end
    end

    assign haz = id_ex_memread && (id_ex_rd != '0) && rs_match;

    // -------------------------------------------------------------------------
    // Stall FSM. IDLE covers the first stall cycle combinationally; STALL
    // covers the remaining LOAD_LAT-1 cycles, tracked by rem.
    // -------------------------------------------------------------------------
    state_t     state, state_nxt;
    logic [3:0] rem, rem_nxt;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        stall     = 1'b0;
        bubble    = 1'b0;

        if (flush) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    stall  = haz;
                    bubble = haz;
                    if (haz && (LOAD_LAT > 1)) begin
                        state_nxt = STALL;
                        rem_nxt   = REM_INIT;
                    end
                end
                STALL: begin
                    // Keep bubbling so the load is not re-issued into EX.
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    rem_nxt = rem - 4'd1;
                    if (rem == 4'd1)
                        state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    rem_nxt   = '0;
                end
            endcase
        end

        // Reset abandons any stall immediately, not at the next edge.
        if (reset) begin
            stall  = 1'b0;
            bubble = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating stall-cycle counter.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Self-checking bench for fwd_hazard_unit. Four instances share one set of
// input stimulus and differ in LOAD_LAT / CNT_W:
//   dut_a : LOAD_LAT=1, CNT_W=16   (forwarding, single-cycle load-use)
//   dut_b : LOAD_LAT=3, CNT_W=16   (multi-cycle load-use)
//   dut_c : LOAD_LAT=4, CNT_W=16   (flush / reset during a stall)
//   dut_d : LOAD_LAT=1, CNT_W=4    (counter saturation)
// Expected values are queued when stimulus is applied and popped when the
// outputs are sampled.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              flush;
    logic [NS*AW-1:0]  ex_rs_addr;
    logic [NS*DW-1:0]  ex_rs_data;
    logic              ex_mem_regwrite;
    logic [AW-1:0]     ex_mem_rd;
    logic [DW-1:0]     ex_mem_data;
    logic              mem_wb_regwrite;
    logic [AW-1:0]     mem_wb_rd;
    logic [DW-1:0]     mem_wb_data;
    logic [NS*AW-1:0]  id_rs_addr;
    logic [NS-1:0]     id_rs_used;
    logic              id_ex_memread;
    logic [AW-1:0]     id_ex_rd;

    logic [2*NS-1:0]   sel_a, sel_b, sel_c, sel_d;
    logic [NS*DW-1:0]  data_a, data_b, data_c, data_d;
    logic              stall_a, stall_b, stall_c, stall_d;
    logic              bubble_a, bubble_b, bubble_c, bubble_d;
    logic [15:0]       cnt_a, cnt_b, cnt_c;
    logic [3:0]        cnt_d;

    fwd_hazard_unit #(.DATA_W(DW), .RADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_data(ex_mem_data),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .fwd_sel(sel_a), .fwd_data(data_a), .stall(stall_a), .bubble(bubble_a), .stall_cnt(cnt_a)
    );

    fwd_hazard_unit #(.DATA_W(DW), .RADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_data(ex_mem_data),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .fwd_sel(sel_b), .fwd_data(data_b), .stall(stall_b), .bubble(bubble_b), .stall_cnt(cnt_b)
    );

    fwd_hazard_unit #(.DATA_W(DW), .RADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(4), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_data(ex_mem_data),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .fwd_sel(sel_c), .fwd_data(data_c), .stall(stall_c), .bubble(bubble_c), .stall_cnt(cnt_c)
    );

    fwd_hazard_unit #(.DATA_W(DW), .RADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(4)) dut_d (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_data(ex_mem_data),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .fwd_sel(sel_d), .fwd_data(data_d), .stall(stall_d), .bubble(bubble_d), .stall_cnt(cnt_d)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        bubble;
        logic [15:0] cnt;
    } ctl_exp_t;

    typedef struct {
        logic [2*NS-1:0]  sel;
        logic [NS*DW-1:0] data;
    } fwd_exp_t;

    typedef struct {
        logic        memread;
        logic [4:0]  rd;
        logic [9:0]  addr;
        logic [1:0]  used;
        logic        fl;
        logic        e_stall;
        logic [15:0] e_cnt;
    } row_t;

    ctl_exp_t ctl_q[$];
    fwd_exp_t fwd_q[$];

    function automatic row_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] a1,
                                input logic [4:0] a0, input logic [1:0] used, input logic fl,
                                input logic es, input logic [15:0] ec);
        row_t r;
        r.memread = mr;
        r.rd      = rd;
        r.addr    = {a1, a0};
        r.used    = used;
        r.fl      = fl;
        r.e_stall = es;
        r.e_cnt   = ec;
        return r;
    endfunction

    // Reference forwarding select, written straight from the priority rules.
    function automatic logic [1:0] ref_sel(input logic [4:0] rs);
        if (ex_mem_regwrite && ex_mem_rd != 5'd0 && ex_mem_rd == rs) return 2'b10;
        if (mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic fwd_exp_t ref_fwd();
        fwd_exp_t e;
        for (int i = 0; i < NS; i++) begin
            logic [1:0] s;
            s = ref_sel(ex_rs_addr[i*AW +: AW]);
            e.sel[2*i +: 2] = s;
            case (s)
                2'b10:   e.data[i*DW +: DW] = ex_mem_data;
                2'b01:   e.data[i*DW +: DW] = mem_wb_data;
                default: e.data[i*DW +: DW] = ex_rs_data[i*DW +: DW];
            endcase
        end
        return e;
    endfunction

    task automatic drive_row(input row_t r);
        id_ex_memread = r.memread;
        id_ex_rd      = r.rd;
        id_rs_addr    = r.addr;
        id_rs_used    = r.used;
        flush         = r.fl;
    endtask

    task automatic clear_inputs();
        flush           = 1'b0;
        ex_rs_addr      = '0;
        ex_rs_data      = '0;
        ex_mem_regwrite = 1'b0;
        ex_mem_rd       = '0;
        ex_mem_data     = '0;
        mem_wb_regwrite = 1'b0;
        mem_wb_rd       = '0;
        mem_wb_data     = '0;
        id_rs_addr      = '0;
        id_rs_used      = '0;
        id_ex_memread   = 1'b0;
        id_ex_rd        = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        ctl_exp_t e;
        // Hazard present while reset is held: outputs still forced low.
        id_ex_memread = 1'b1;
        id_ex_rd      = 5'd5;
        id_rs_addr    = {5'd5, 5'd5};
        id_rs_used    = 2'b11;
        reset         = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ctl_q.push_back('{stall: 1'b0, bubble: 1'b0, cnt: 16'd0});
            @(negedge clk);
            e = ctl_q.pop_front();
            checks++;
            if ({stall_a, stall_b, stall_c, stall_d} !== {4{e.stall}} ||
                {bubble_a, bubble_b, bubble_c, bubble_d} !== {4{e.bubble}} ||
                cnt_a !== e.cnt || cnt_b !== e.cnt || cnt_c !== e.cnt || cnt_d !== e.cnt[3:0]) begin
                errors++;
                $display("FAIL reset[%0d]: stall=%b%b%b%b bubble=%b%b%b%b cnt=%0d/%0d/%0d/%0d, required all 0",
                         k, stall_a, stall_b, stall_c, stall_d, bubble_a, bubble_b, bubble_c, bubble_d,
                         cnt_a, cnt_b, cnt_c, cnt_d);
            end
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_fwd_directed();
        fwd_exp_t exp_list[$];
        fwd_exp_t e;
        clear_inputs();
        ex_rs_data = {32'h3333_3333, 32'h0000_AAAA};

        // Double hazard on slot 0: EX/MEM wins.
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd8; ex_mem_data = 32'h1111;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd8; mem_wb_data = 32'h2222;
        ex_rs_addr = {5'd3, 5'd8};
        fwd_q.push_back('{sel: 4'b0010, data: {32'h3333_3333, 32'h0000_1111}});
        #1;
        e = fwd_q.pop_front();
        checks++;
        if (sel_a !== e.sel || data_a !== e.data) begin
            errors++;
            $display("FAIL fwd_exmem: sel=%b data=%h, required sel=%b data=%h", sel_a, data_a, e.sel, e.data);
        end

        // MEM/WB on slot 0.
        mem_wb_rd = 5'd9; mem_wb_data = 32'hABCD;
        ex_rs_addr = {5'd3, 5'd9};
        fwd_q.push_back('{sel: 4'b0001, data: {32'h3333_3333, 32'h0000_ABCD}});
        #1;
        e = fwd_q.pop_front();
        checks++;
        if (sel_a !== e.sel || data_a !== e.data) begin
            errors++;
            $display("FAIL fwd_memwb: sel=%b data=%h, required sel=%b data=%h", sel_a, data_a, e.sel, e.data);
        end

        // Slot 1 from EX/MEM while slot 0 from MEM/WB.
        ex_rs_addr = {5'd8, 5'd9};
        fwd_q.push_back('{sel: 4'b1001, data: {32'h0000_1111, 32'h0000_ABCD}});
        #1;
        e = fwd_q.pop_front();
        checks++;
        if (sel_a !== e.sel || data_a !== e.data) begin
            errors++;
            $display("FAIL fwd_both_slots: sel=%b data=%h, required sel=%b data=%h", sel_a, data_a, e.sel, e.data);
        end

        // Register 0 is never forwarded even with writers targeting it.
        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
        ex_rs_addr = {5'd0, 5'd0};
        fwd_q.push_back('{sel: 4'b0000, data: {32'h3333_3333, 32'h0000_AAAA}});
        #1;
        e = fwd_q.pop_front();
        checks++;
        if (sel_a !== e.sel || data_a !== e.data) begin
            errors++;
            $display("FAIL fwd_r0: sel=%b data=%h, required sel=%b data=%h", sel_a, data_a, e.sel, e.data);
        end

        // Writers disabled: matching rd must not forward.
        ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
        ex_mem_rd = 5'd4; mem_wb_rd = 5'd4;
        ex_rs_addr = {5'd4, 5'd4};
        fwd_q.push_back('{sel: 4'b0000, data: {32'h3333_3333, 32'h0000_AAAA}});
        #1;
        e = fwd_q.pop_front();
        checks++;
        if (sel_a !== e.sel || data_a !== e.data) begin
            errors++;
            $display("FAIL fwd_no_we: sel=%b data=%h, required sel=%b data=%h", sel_a, data_a, e.sel, e.data);
        end
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_fwd_random();
        fwd_exp_t e;
        for (int k = 0; k < 24; k++) begin
            ex_mem_regwrite = 1'($urandom_range(0, 1));
            mem_wb_regwrite = 1'($urandom_range(0, 1));
            ex_mem_rd       = 5'($urandom_range(0, 3));
            mem_wb_rd       = 5'($urandom_range(0, 3));
            ex_mem_data     = $urandom;
            mem_wb_data     = $urandom;
            ex_rs_addr      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ex_rs_data      = {$urandom, $urandom};
            fwd_q.push_back(ref_fwd());
            #1;
            e = fwd_q.pop_front();
            checks++;
            if (sel_a !== e.sel || data_a !== e.data || sel_d !== e.sel || data_d !== e.data) begin
                errors++;
                $display("FAIL fwd_random[%0d]: sel=%b data=%h, required sel=%b data=%h",
                         k, sel_a, data_a, e.sel, e.data);
            end
        end
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_load_use_single();
        row_t rows[$];
        ctl_exp_t e;
        pulse_reset();
        rows.push_back(mk(1, 5'd5, 5'd5, 5'd2, 2'b10, 0, 1, 16'd0)); // slot 1 hazard
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 0, 16'd1)); // load gone
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 0, 16'd1));
        rows.push_back(mk(1, 5'd5, 5'd5, 5'd2, 2'b00, 0, 0, 16'd1)); // operand unused
        rows.push_back(mk(1, 5'd5, 5'd5, 5'd5, 2'b00, 0, 0, 16'd1));
        rows.push_back(mk(1, 5'd5, 5'd7, 5'd5, 2'b01, 0, 1, 16'd1)); // slot 0 hazard
        rows.push_back(mk(0, 5'd5, 5'd7, 5'd5, 2'b01, 0, 0, 16'd2));
        rows.push_back(mk(1, 5'd0, 5'd0, 5'd0, 2'b11, 0, 0, 16'd2)); // load to $0
        rows.push_back(mk(1, 5'd6, 5'd7, 5'd5, 2'b11, 0, 0, 16'd2)); // no address match
        foreach (rows[k]) begin
            @(posedge clk); #1;
            drive_row(rows[k]);
            ctl_q.push_back('{stall: rows[k].e_stall, bubble: rows[k].e_stall, cnt: rows[k].e_cnt});
            @(negedge clk);
            e = ctl_q.pop_front();
            checks++;
            if (stall_a !== e.stall || bubble_a !== e.bubble || cnt_a !== e.cnt) begin
                errors++;
                $display("FAIL load_use_1[%0d]: stall=%b bubble=%b cnt=%0d, required stall=%b bubble=%b cnt=%0d",
                         k, stall_a, bubble_a, cnt_a, e.stall, e.bubble, e.cnt);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_load_use_multi();
        row_t rows[$];
        ctl_exp_t e;
        pulse_reset();
        rows.push_back(mk(1, 5'd5, 5'd5, 5'd2, 2'b10, 0, 1, 16'd0));
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 1, 16'd1));
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 1, 16'd2));
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 0, 16'd3));
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 0, 16'd3));
        foreach (rows[k]) begin
            @(posedge clk); #1;
            drive_row(rows[k]);
            ctl_q.push_back('{stall: rows[k].e_stall, bubble: rows[k].e_stall, cnt: rows[k].e_cnt});
            @(negedge clk);
            e = ctl_q.pop_front();
            checks++;
            if (stall_b !== e.stall || bubble_b !== e.bubble || cnt_b !== e.cnt) begin
                errors++;
                $display("FAIL load_use_3[%0d]: stall=%b bubble=%b cnt=%0d, required stall=%b bubble=%b cnt=%0d",
                         k, stall_b, bubble_b, cnt_b, e.stall, e.bubble, e.cnt);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_flush_reset();
        row_t rows[$];
        ctl_exp_t e;
        pulse_reset();
        rows.push_back(mk(1, 5'd5, 5'd5, 5'd2, 2'b10, 0, 1, 16'd0)); // stall cycle 1
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 1, 0, 16'd1)); // flush in cycle 2
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 0, 16'd1)); // back in IDLE
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 0, 16'd1));
        rows.push_back(mk(1, 5'd5, 5'd5, 5'd2, 2'b10, 1, 0, 16'd1)); // flush beats haz
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 0, 16'd1)); // no stall entered
        rows.push_back(mk(1, 5'd5, 5'd5, 5'd2, 2'b10, 0, 1, 16'd1)); // new hazard
        rows.push_back(mk(0, 5'd5, 5'd5, 5'd2, 2'b10, 0, 1, 16'd2)); // in STALL
        foreach (rows[k]) begin
            @(posedge clk); #1;
            drive_row(rows[k]);
            ctl_q.push_back('{stall: rows[k].e_stall, bubble: rows[k].e_stall, cnt: rows[k].e_cnt});
            @(negedge clk);
            e = ctl_q.pop_front();
            checks++;
            if (stall_c !== e.stall || bubble_c !== e.bubble || cnt_c !== e.cnt) begin
                errors++;
                $display("FAIL flush_4[%0d]: stall=%b bubble=%b cnt=%0d, required stall=%b bubble=%b cnt=%0d",
                         k, stall_c, bubble_c, cnt_c, e.stall, e.bubble, e.cnt);
            end
        end

        // Asynchronous reset in the middle of the stall.
        reset = 1'b1;
        ctl_q.push_back('{stall: 1'b0, bubble: 1'b0, cnt: 16'd0});
        #1;
        e = ctl_q.pop_front();
        checks++;
        if (stall_c !== e.stall || bubble_c !== e.bubble || cnt_c !== e.cnt) begin
            errors++;
            $display("FAIL reset_mid_stall: stall=%b bubble=%b cnt=%0d, required stall=0 bubble=0 cnt=0",
                     stall_c, bubble_c, cnt_c);
        end
        #1;
        reset = 1'b0;

        // Stall must not resume once reset is released.
        @(posedge clk); #1;
        ctl_q.push_back('{stall: 1'b0, bubble: 1'b0, cnt: 16'd0});
        @(negedge clk);
        e = ctl_q.pop_front();
        checks++;
        if (stall_c !== e.stall || bubble_c !== e.bubble || cnt_c !== e.cnt) begin
            errors++;
            $display("FAIL after_reset: stall=%b bubble=%b cnt=%0d, required stall=0 bubble=0 cnt=0",
                     stall_c, bubble_c, cnt_c);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_saturation();
        ctl_exp_t e;
        int       expc;
        pulse_reset();
        for (int k = 0; k < 21; k++) begin
            @(posedge clk); #1;
            // Hazard held for 20 cycles, then released.
            drive_row(mk(k < 20 ? 1'b1 : 1'b0, 5'd5, 5'd5, 5'd5, 2'b11, 0, 0, 16'd0));
            expc = (k > 15) ? 15 : k;
            ctl_q.push_back('{stall: (k < 20), bubble: (k < 20), cnt: 16'(expc)});
            @(negedge clk);
            e = ctl_q.pop_front();
            checks++;
            if (stall_d !== e.stall || bubble_d !== e.bubble || cnt_d !== e.cnt[3:0]) begin
                errors++;
                $display("FAIL saturate[%0d]: stall=%b bubble=%b cnt=%0d, required stall=%b bubble=%b cnt=%0d",
                         k, stall_d, bubble_d, cnt_d, e.stall, e.bubble, e.cnt);
            end
        end
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        reset = 1'b0;
        clear_inputs();
        #1;
        test_reset();
        test_fwd_directed();
        test_fwd_random();
        test_load_use_single();
        test_load_use_multi();
        test_flush_reset();
        test_saturation();
        if (ctl_q.size() != 0 || fwd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", ctl_q.size(), fwd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the 5-stage pipeline; generalises the 3:1 operand forwarding mux to NUM_SRC operands.
- Computes per-operand forwarding selects and forwarded data in EX.
- Detects load-use hazards against the ID stage and runs a stall FSM, which supports multi-cycle data memory (LOAD_LAT cycles).
- Drives PC/IF-ID hold and the ID/EX bubble, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, operand width.
- RADDR_W, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction (1..4).
- LOAD_LAT, 1, stall cycles per load-use hazard (1..15).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears FSM and counter.
- flush  in  1  synchronous branch/jump flush; aborts any stall.
- ex_rs_addr  in  NUM_SRC*RADDR_W  EX-stage source register numbers; slot i at [i*RADDR_W +: RADDR_W].
- ex_rs_data  in  NUM_SRC*DATA_W  EX-stage register-file values (ID/EX latched).
- ex_mem_regwrite  in  1  EX/MEM writes the register file.
- ex_mem_rd  in  RADDR_W  EX/MEM destination register.
- ex_mem_data  in  DATA_W  EX/MEM ALU result.
- mem_wb_regwrite  in  1  MEM/WB writes the register file.
- mem_wb_rd  in  RADDR_W  MEM/WB destination register.
- mem_wb_data  in  DATA_W  MEM/WB write-back value.
- id_rs_addr  in  NUM_SRC*RADDR_W  ID-stage source register numbers.
- id_rs_used  in  NUM_SRC  per-slot "operand actually read" flags.
- id_ex_memread  in  1  instruction in ID/EX is a load.
- id_ex_rd  in  RADDR_W  ID/EX destination register.
- fwd_sel  out  2*NUM_SRC  per-slot select: 00 register file, 01 MEM/WB, 10 EX/MEM.
- fwd_data  out  NUM_SRC*DATA_W  forwarded operands.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero ID/EX control signals.
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating.

Behaviour:
- Forwarding is combinational and evaluated independently per slot i.
  - Select 10 if ex_mem_regwrite and ex_mem_rd != 0 and ex_mem_rd == rs_i.
  - Else select 01 if mem_wb_regwrite and mem_wb_rd != 0 and mem_wb_rd == rs_i.
  - Else select 00.
  - EX/MEM has priority when both stages match (double data hazard).
  - Register 0 is never forwarded; fwd_data_i = ex_rs_data_i when rs_i == 0.
  - Encoding 11 is never produced. fwd_data for an 11 select would be 0 (kept for encoding compatibility).
- Hazard term: haz = id_ex_memread and id_ex_rd != 0 and, for some i, id_rs_used[i] and id_rs_addr_i == id_ex_rd.
- FSM states: IDLE, STALL; 4-bit down-counter rem.
  - IDLE: stall = bubble = haz.
    - If haz and LOAD_LAT > 1: next state STALL, rem <= LOAD_LAT-1.
    - Otherwise stay in IDLE.
  - STALL: stall = 1. bubble = 1, so no duplicate load re-enters EX.
    - rem decrements each cycle; when rem == 1, next state is IDLE.
  - Each hazard therefore produces exactly LOAD_LAT consecutive stall cycles.
  - The hazard is not re-detected after the bubble, because id_ex_memread drops.
- flush:
  - Forces stall = bubble = 0 in the same cycle.
  - Next state IDLE, rem <= 0. A flush overrides haz in the same cycle.
- stall_cnt:
  - Increments on each rising edge where stall == 1.
  - Saturates at all-ones and never wraps.
- Reset while asserted:
  - State IDLE, rem = 0, stall_cnt = 0.
  - stall and bubble are forced 0.
  - fwd_sel and fwd_data remain combinational functions of the inputs.
  - Reset mid-STALL abandons the stall immediately.
- No latches: all combinational outputs are fully assigned on every path.

Test Plan:
1. EX/MEM forwarding: ex_mem_regwrite=1, rd=8, data=0x1111; mem_wb_regwrite=1, rd=8, data=0x2222; rs0=8 -> fwd_sel[1:0]=10, fwd_data0=0x1111.
2. MEM/WB forwarding and $0: rs0=9, mem_wb rd=9, data=0xABCD -> sel 01, data 0xABCD. Then all rd=0 with regwrite=1 and rs0=0 -> sel 00, data=ex_rs_data0.
3. Single-cycle load-use, LOAD_LAT=1: id_ex_memread=1, id_ex_rd=5, id_rs_addr1=5, id_rs_used=2'b10 -> stall=bubble=1 for exactly 1 cycle; stall_cnt=1. Same stimulus with id_rs_used=2'b00 -> no stall.
4. Multi-cycle load-use, LOAD_LAT=3: hazard pulse for 1 cycle -> stall=1 for 3 consecutive cycles, then 0; stall_cnt=3.
5. Flush and reset during STALL, LOAD_LAT=4: flush in the 2nd stall cycle -> stall=0 that cycle and FSM in IDLE. A new hazard followed by async reset mid-stall -> stall=0 immediately and stall_cnt=0.
6. Counter saturation, CNT_W=4: hold a hazard continuously for 20 cycles -> stall_cnt stops at 15 and does not wrap.
